// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Time-shares one external WIDTH-bit adder among NUM_REQ requesters.
//   A round-robin arbiter picks one pending request in IDLE. The winner's
//   operands are latched onto the adder inputs for one cycle (EXEC). The
//   adder result is then captured and offered on a valid/ready response
//   channel tagged with the requester index (RESP).
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req/req_a/req_b/req_cin  per-requester request level and packed operands
//                            (requester k uses bits [k*WIDTH +: WIDTH])
//   gnt                   one-hot accept pulse, high for the EXEC cycle only
//   add_i0/add_i1/add_cin operands driven to the shared adder
//   add_sum/add_cout      combinational result from the shared adder
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_sum/rsp_cout  owner index and captured result
//   busy                  high whenever the FSM is not in IDLE
//   op_count              completed-operation counter (wraps)
module adder_share_arbiter #(
  parameter int   WIDTH   = 16,
  parameter int   NUM_REQ = 4,
  localparam int  IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         add_i0,
  output logic [WIDTH-1:0]         add_i1,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy,
  output logic [15:0]              op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]     add_i0_q, add_i0_d;
  logic [WIDTH-1:0]     add_i1_q, add_i1_d;
  logic                 add_cin_q, add_cin_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]     rsp_sum_q, rsp_sum_d;
  logic                 rsp_cout_q, rsp_cout_d;
  logic [15:0]          op_count_q, op_count_d;

  // Round-robin search: first set req bit at or above rr_ptr, wrapping.
  logic                 win_found;
  logic [IDW-1:0]       win_idx;
  int                   cand;
  logic [IDW-1:0]       cand_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and registered-output logic. The owner index lives in
  // rsp_id, which is also what advances the pointer on completion.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    add_i0_d    = add_i0_q;
    add_i1_d    = add_i1_q;
    add_cin_d   = add_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          add_i0_d  = req_a[int'(win_idx)*WIDTH +: WIDTH];
          add_i1_d  = req_b[int'(win_idx)*WIDTH +: WIDTH];
          add_cin_d = req_cin[win_idx];
          gnt_d     = NUM_REQ'(1) << win_idx;
          rsp_id_d  = win_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = add_sum;
        rsp_cout_d  = add_cout;
        rsp_valid_d = 1'b1;
        gnt_d       = '0;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (rsp_id_q == IDW'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
          op_count_d  = op_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      add_i0_q    <= '0;
      add_i1_q    <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      add_i0_q    <= add_i0_d;
      add_i1_q    <= add_i1_d;
      add_cin_q   <= add_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      op_count_q  <= op_count_d;
    end
  end

  assign gnt       = gnt_q;
  assign add_i0    = add_i0_q;
  assign add_i1    = add_i1_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, req_cin, gnt;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   add_i0, add_i1, add_sum, rsp_sum;
  logic           add_cin, add_cout, rsp_valid, rsp_ready, rsp_cout, busy;
  logic [1:0]     rsp_id;
  logic [15:0]    op_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state: requester operands, arbitration pointer, op count.
  logic [W-1:0] a_m [N];
  logic [W-1:0] b_m [N];
  logic         cin_m [N];
  int           rr_m;
  int           ops_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The shared external adder.
  assign {add_cout, add_sum} = {1'b0, add_i0} + {1'b0, add_i1} + {16'd0, add_cin};

  adder_share_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .gnt(gnt), .add_i0(add_i0), .add_i1(add_i1),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy), .op_count(op_count)
  );

  // Round-robin rule: first requesting index at or after ptr, wrapping.
  function automatic int pick(logic [N-1:0] r, int ptr);
    for (int i = 0; i < N; i++) begin
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [W:0] ref_sum(int k);
    return {1'b0, a_m[k]} + {1'b0, b_m[k]} + (W+1)'(cin_m[k]);
  endfunction

  task automatic load_ops();
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = a_m[k];
      req_b[k*W +: W] = b_m[k];
      req_cin[k]      = cin_m[k];
    end
  endtask

  task automatic rand_ops(int k);
    a_m[k]   = 16'($urandom);
    b_m[k]   = 16'($urandom);
    cin_m[k] = 1'($urandom);
  endtask

  // Drives one operation to completion from an IDLE negedge with req already
  // set; returns what the DUT granted and responded (no judging here).
  task automatic serve_one(input int stall, output logic [N-1:0] g, output logic [1:0] id,
                           output logic [W-1:0] s, output logic c, output bit to);
    int n;
    to = 0; n = 0; g = '0; id = '0; s = '0; c = 1'b0;
    while (gnt == 0 && n < 10) begin @(negedge clk); n++; end
    if (gnt == 0) begin to = 1; return; end
    g = gnt;
    req = req & ~gnt;
    rsp_ready = (stall == 0);
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 5) begin @(negedge clk); n++; end
    if (!rsp_valid) begin to = 1; return; end
    repeat (stall) @(negedge clk);
    id = rsp_id; s = rsp_sum; c = rsp_cout;
    rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
    for (int k = 0; k < N; k++) begin a_m[k] = '0; b_m[k] = '0; cin_m[k] = 1'b0; end
    repeat (3) @(negedge clk);
    checks++; if ({gnt, rsp_valid, busy} !== '0) begin errors++;
      $display("FAIL reset_ctrl: gnt=%b rsp_valid=%b busy=%b required all 0", gnt, rsp_valid, busy); end
    checks++; if ({add_i0, add_i1, add_cin} !== '0) begin errors++;
      $display("FAIL reset_adder: i0=%h i1=%h cin=%b required 0", add_i0, add_i1, add_cin); end
    checks++; if ({rsp_id, rsp_sum, rsp_cout} !== '0) begin errors++;
      $display("FAIL reset_rsp: id=%0d sum=%h cout=%b required 0", rsp_id, rsp_sum, rsp_cout); end
    checks++; if (op_count !== 16'd0) begin errors++;
      $display("FAIL reset_count: got %h required 0000", op_count); end
    rst_n = 1'b1;
    @(negedge clk);
    rr_m = 0; ops_m = 0;
  endtask

  task automatic test_basic();
    int n;
    a_m[0] = 16'h1234; b_m[0] = 16'h0F0F; cin_m[0] = 1'b0; load_ops();
    req = 4'b0001; rsp_ready = 1'b0; n = 0;
    do begin @(negedge clk); n++; end while (gnt == 0 && n < 10);
    checks++; if (gnt !== 4'b0001 || n != 1) begin errors++;
      $display("FAIL basic_gnt: gnt=%b after %0d cycles required 0001 after 1", gnt, n); end
    checks++; if (add_i0 !== 16'h1234 || add_i1 !== 16'h0F0F || add_cin !== 1'b0) begin errors++;
      $display("FAIL basic_operands: i0=%h i1=%h cin=%b required 1234 0f0f 0", add_i0, add_i1, add_cin); end
    req = '0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || rsp_valid !== 1'b1) begin errors++;
      $display("FAIL basic_valid: gnt=%b rsp_valid=%b required 0000 1", gnt, rsp_valid); end
    checks++; if (rsp_id !== 2'd0 || rsp_sum !== 16'h2143 || rsp_cout !== 1'b0) begin errors++;
      $display("FAIL basic_rsp: id=%0d sum=%h cout=%b required 0 2143 0", rsp_id, rsp_sum, rsp_cout); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rr_m = 1; ops_m = 1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd1) begin errors++;
      $display("FAIL basic_done: valid=%b busy=%b count=%h required 0 0 0001", rsp_valid, busy, op_count); end
    $display("basic: a=1234 b=0f0f -> sum=%h cout=%b id=%0d", rsp_sum, rsp_cout, rsp_id);
  endtask

  task automatic test_round_robin();
    int prev, n, w;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    rr_m = 0; ops_m = 0; prev = 0;
    for (int k = 0; k < N; k++) rand_ops(k);
    load_ops();
    req = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (gnt == 0 && n < 10) begin @(negedge clk); n++; end
      if (gnt == 0) begin
        errors++; checks++; req = '0;
        $display("FAIL rr_timeout: no gnt within 10 cycles for op %0d", k); return;
      end
      w = pick(req, rr_m);
      checks++; if (gnt !== 4'(1 << w)) begin errors++;
        $display("FAIL rr_order: op %0d gnt=%b required %b", k, gnt, 4'(1 << w)); end
      if (k > 0) begin
        checks++; if (cyc - prev != 3) begin errors++;
          $display("FAIL rr_spacing: %0d cycles between grants required 3", cyc - prev); end
      end
      prev = cyc;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(w) || {rsp_cout, rsp_sum} !== ref_sum(w)) begin
        errors++; $display("FAIL rr_rsp: valid=%b id=%0d cout/sum=%h required 1 %0d %h",
                           rsp_valid, rsp_id, {rsp_cout, rsp_sum}, w, ref_sum(w)); end
      $display("rr: op %0d id=%0d sum=%h cout=%b", k, rsp_id, rsp_sum, rsp_cout);
      rr_m = (w + 1) % N; ops_m++;
      if (k == 4) req = '0;
      @(negedge clk);
      checks++; if (op_count !== 16'(ops_m)) begin errors++;
        $display("FAIL rr_count: got %h required %h", op_count, 16'(ops_m)); end
    end
  endtask

  task automatic test_carry();
    logic [N-1:0] g; logic [1:0] id; logic [W-1:0] s; logic c; bit to;
    a_m[2] = 16'hFFFF; b_m[2] = 16'h0001; cin_m[2] = 1'b1; load_ops();
    req = 4'b0100;
    serve_one(0, g, id, s, c, to);
    rr_m = 3; ops_m++;
    checks++; if (to || g !== 4'b0100 || id !== 2'd2) begin errors++;
      $display("FAIL carry_gnt: timeout=%0d gnt=%b id=%0d required 0 0100 2", to, g, id); end
    checks++; if (s !== 16'h0001 || c !== 1'b1) begin errors++;
      $display("FAIL carry_sum: sum=%h cout=%b required 0001 1", s, c); end
    $display("carry: ffff+0001+1 -> sum=%h cout=%b id=%0d", s, c, id);
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g; logic [1:0] id; logic [W-1:0] s; logic c; bit to;
    int n, w, w2;
    for (int k = 0; k < N; k++) rand_ops(k);
    load_ops();
    rsp_ready = 1'b0; req = 4'b1001;
    w = pick(req, rr_m); n = 0;
    while (gnt == 0 && n < 10) begin @(negedge clk); n++; end
    checks++; if (gnt !== 4'(1 << w)) begin errors++;
      $display("FAIL bp_gnt: gnt=%b required %b", gnt, 4'(1 << w)); end
    req = req & ~4'(1 << w);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || busy !== 1'b1 || gnt !== 4'b0000 || rsp_id !== 2'(w) ||
          {rsp_cout, rsp_sum} !== ref_sum(w)) begin
        errors++; $display("FAIL bp_hold: cycle %0d valid=%b busy=%b gnt=%b id=%0d cout/sum=%h required 1 1 0000 %0d %h",
                           i, rsp_valid, busy, gnt, rsp_id, {rsp_cout, rsp_sum}, w, ref_sum(w));
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rr_m = (w + 1) % N; ops_m++;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL bp_release: valid=%b busy=%b required 0 0", rsp_valid, busy); end
    w2 = pick(req, rr_m);
    serve_one(0, g, id, s, c, to);
    rr_m = (w2 + 1) % N; ops_m++;
    checks++; if (to || g !== 4'(1 << w2) || {c, s} !== ref_sum(w2)) begin errors++;
      $display("FAIL bp_next: timeout=%0d gnt=%b cout/sum=%h required 0 %b %h", to, g, {c, s}, 4'(1 << w2), ref_sum(w2)); end
    checks++; if (op_count !== 16'(ops_m)) begin errors++;
      $display("FAIL bp_count: got %h required %h", op_count, 16'(ops_m)); end
    $display("backpressure: held id=%0d, then id=%0d sum=%h", w, id, s);
  endtask

  task automatic test_random();
    logic [N-1:0] g; logic [1:0] id; logic [W-1:0] s; logic c; bit to;
    int w, stall;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(0, 1) == 1) begin rand_ops(k); req[k] = 1'b1; end
      end
      if (req == '0) begin w = $urandom_range(0, N - 1); rand_ops(w); req[w] = 1'b1; end
      load_ops();
      w = pick(req, rr_m);
      stall = $urandom_range(0, 3);
      serve_one(stall, g, id, s, c, to);
      rr_m = (w + 1) % N; ops_m = (ops_m + 1) % 65536;
      checks++;
      if (to || g !== 4'(1 << w) || id !== 2'(w) || {c, s} !== ref_sum(w) || op_count !== 16'(ops_m)) begin
        errors++; $display("FAIL rand_op: it %0d timeout=%0d gnt=%b id=%0d cout/sum=%h count=%h required %b %0d %h %h",
                           it, to, g, id, {c, s}, op_count, 4'(1 << w), w, ref_sum(w), 16'(ops_m));
      end
      $display("rand: it %0d id=%0d a=%h b=%h cin=%b -> sum=%h cout=%b", it, id, a_m[w], b_m[w], cin_m[w], s, c);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g; logic [1:0] id; logic [W-1:0] s; logic c; bit to;
    int n;
    rand_ops(0); load_ops();
    req = 4'b0001; rsp_ready = 1'b1; n = 0;
    while (gnt == 0 && n < 10) begin @(negedge clk); n++; end
    rst_n = 1'b0; req = '0;
    #1;
    checks++; if ({gnt, rsp_valid, busy, rsp_id, rsp_sum, rsp_cout} !== '0) begin errors++;
      $display("FAIL mid_reset_rsp: gnt=%b valid=%b busy=%b id=%0d sum=%h cout=%b required 0",
               gnt, rsp_valid, busy, rsp_id, rsp_sum, rsp_cout); end
    checks++; if ({add_i0, add_i1, add_cin} !== '0 || op_count !== 16'd0) begin errors++;
      $display("FAIL mid_reset_dp: i0=%h i1=%h cin=%b count=%h required 0", add_i0, add_i1, add_cin, op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0; ops_m = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin errors++;
        $display("FAIL mid_quiet: cycle %0d valid=%b gnt=%b busy=%b required 0", i, rsp_valid, gnt, busy); end
    end
    for (int k = 0; k < N; k++) rand_ops(k);
    load_ops();
    req = 4'b1010;
    serve_one(0, g, id, s, c, to);
    req = '0;
    rr_m = 2; ops_m = 1;
    checks++; if (to || g !== 4'b0010 || id !== 2'd1 || {c, s} !== ref_sum(1)) begin errors++;
      $display("FAIL mid_first: timeout=%0d gnt=%b id=%0d cout/sum=%h required 0 0010 1 %h", to, g, id, {c, s}, ref_sum(1)); end
    $display("reset_mid: first grant after reset id=%0d", id);
  endtask

  task automatic test_wrap();
    logic [N-1:0] g; logic [1:0] id; logic [W-1:0] s; logic c; bit to;
    @(negedge clk);
    force dut.op_count_d = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_d;
    @(negedge clk);
    ops_m = 65535;
    checks++; if (op_count !== 16'hFFFF) begin errors++;
      $display("FAIL wrap_preload: got %h required ffff", op_count); end
    rand_ops(0); load_ops();
    req = 4'b0001;
    serve_one(0, g, id, s, c, to);
    ops_m = (ops_m + 1) % 65536;
    checks++; if (to || op_count !== 16'(ops_m)) begin errors++;
      $display("FAIL wrap_count: timeout=%0d got %h required %h", to, op_count, 16'(ops_m)); end
    $display("wrap: op_count=%h", op_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_carry();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one external 16-bit carry-select adder among NUM_REQ requesters.
- Arbitration is round-robin. The block latches the winner's operands, drives the adder for one cycle, captures the result and returns it over a valid/ready response channel tagged with the requester ID.
- Sits between the requester blocks and the single carry_select_adder-style datapath instance.

Parameters:
- WIDTH, 16, operand/sum width; must match the shared adder.
- NUM_REQ, 4, number of requesters; IDW = clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request, level.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester k uses bits [k*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing.
- req_cin  in  NUM_REQ  per-requester carry-in.
- gnt  out  NUM_REQ  one-hot, single-cycle accept pulse.
- add_i0  out  WIDTH  to adder I0.
- add_i1  out  WIDTH  to adder I1.
- add_cin  out  1  to adder cin.
- add_sum  in  WIDTH  from adder (combinational result).
- add_cout  in  1  from adder.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  WIDTH  captured sum.
- rsp_cout  out  1  captured carry-out.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  completed-operation counter.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, and these outputs are 0: gnt, add_i0, add_i1, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, op_count.
- All outputs are registered. No combinational path from any input to any output.
- Three-state FSM, IDLE -> EXEC -> RESP -> IDLE:
  - IDLE: if req != 0, pick the winner w. w is the first set bit searching upward from rr_ptr and wrapping at NUM_REQ-1 -> 0. At the edge: add_i0/add_i1/add_cin <= req_a/req_b/req_cin of w; gnt <= onehot(w); rsp_id <= w; go to EXEC. If req == 0, stay in IDLE and outputs hold.
  - EXEC: gnt = onehot(w) for exactly this cycle, the adder is driven from the latched operands. At the edge: rsp_sum <= add_sum, rsp_cout <= add_cout, rsp_valid <= 1, gnt <= 0, go to RESP.
  - RESP: rsp_valid, rsp_id, rsp_sum and rsp_cout hold stable until rsp_ready=1 is sampled. At that edge: rsp_valid <= 0; rr_ptr <= (w+1) mod NUM_REQ; op_count <= op_count+1 (wraps at 0xFFFF -> 0); go to IDLE.
- Latency: req sampled at edge t -> gnt high in cycle t+1 -> rsp_valid high from cycle t+2.
- Maximum throughput is one operation per 3 cycles, achieved when rsp_ready is held high.
- add_i0, add_i1 and add_cin keep their last values outside EXEC; they are not cleared.
- Requester rules:
  - Hold req, req_a, req_b and req_cin stable until gnt is seen.
  - Deassert req in the cycle gnt is high, unless a new operation is wanted.
  - Requests that are not granted are held; none are dropped.
- Simultaneous requests: only one grant per arbitration, chosen by rr_ptr. A requester granted last has lowest priority next time.
- A req deasserted before it is granted is never served. Arbitration looks only at req sampled in IDLE.
- rsp_ready high outside RESP is ignored.
- Arithmetic is full WIDTH with carry. The block never modifies operands; the sum is exactly what the adder returns.
- Reset asserted mid-operation: immediate return to the reset state and the in-flight result is discarded. No gnt or rsp_valid pulse follows the release of reset.

Test Plan:
- Reset, then req=0001 with a0=0x1234, b0=0x0F0F, cin0=0 -> gnt=0001 one cycle, then rsp_valid=1, rsp_id=0, rsp_sum=0x2143, rsp_cout=0, op_count=1 after rsp_ready.
- req=1111 held continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one result every 3 cycles; each result matches its requester's operands.
- Requester 2 with a=0xFFFF, b=0x0001, cin=1 -> rsp_sum=0x0001, rsp_cout=1, rsp_id=2.
- rsp_ready held at 0 for 10 cycles in RESP -> rsp_valid/rsp_sum stay stable, busy=1, no new gnt; release -> next grant starts in IDLE.
- rst_n pulsed low during EXEC -> all outputs 0 immediately, no rsp_valid after release, rr_ptr=0 so req=1010 grants requester 1 first.
- Preload op_count to 0xFFFF via 65535 operations (or force) -> next completion wraps op_count to 0x0000.
